// File: rtl/seg7_value_display_if.sv
// seg7_value_display_if: load request and segment outputs of seg7_value_display.
interface seg7_value_display_if;
    logic [23:0] value;
    logic        load;
    logic        dec_mode;
    logic [5:0]  dp_mask;
    logic        busy;
    logic [7:0]  hex0, hex1, hex2, hex3, hex4, hex5;
    modport master (
        output value, load, dec_mode, dp_mask,
        input  busy, hex0, hex1, hex2, hex3, hex4, hex5
    );
    modport slave (
        input  value, load, dec_mode, dp_mask,
        output busy, hex0, hex1, hex2, hex3, hex4, hex5
    );
endinterface

// File: rtl/seg7_value_display.sv
// seg7_value_display: six-digit hex/decimal seven-segment driver with a double-dabble converter.
// Define SEG7_LEADING_ZERO_BLANK_EN to blank leading zeros in decimal mode.
module seg7_value_display #(
    parameter int CONV_CYCLES = 24
) (
    input logic max10_clk1_50,
    input logic reset,
    seg7_value_display_if.slave bus
);
    localparam int CW = $clog2(CONV_CYCLES + 1);
    localparam logic [7:0] SEG [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam bit BLANK_EN = 1'b1;
`else
    localparam bit BLANK_EN = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
    state_t state, next_state;
    logic [23:0] bin, bcd, bcd_adj, hex_val;
    logic [CW-1:0] cnt;
    logic [5:0] mask;
    logic ovf, hex_pend, accept, commit, lead;
    logic [3:0] digit;
    logic [7:0] hex_q [6];
    logic [7:0] nxt_seg [6];
    always_ff @(posedge max10_clk1_50)
        state <= reset ? IDLE : next_state;
    always_comb
        next_state = state == IDLE  ? (accept && bus.dec_mode ? SHIFT : IDLE) :
                     state == SHIFT ? (cnt == CW'(CONV_CYCLES - 1) ? COMMIT : SHIFT) : IDLE;
    always_comb begin
        bus.busy = state != IDLE;
        accept   = bus.load && state == IDLE;
        commit   = state == COMMIT;
    end
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 6; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
    // Walk from hex5 down; lead stays set only while every digit seen so far is zero.
    always_comb begin
        lead  = 1'b1;
        digit = '0;
        for (int i = 5; i >= 0; i--) begin
            digit = hex_pend ? hex_val[4*i +: 4] : bcd[4*i +: 4];
            lead = lead && digit == 4'd0 && i != 0 && !hex_pend;
            nxt_seg[i] = {~mask[i], (!hex_pend && ovf) ? 7'h3F :
                                    (lead && BLANK_EN) ? 7'h7F : SEG[digit][6:0]};
        end
    end
    always_ff @(posedge max10_clk1_50) begin
        if (reset) begin
            bin      <= '0;
            bcd      <= '0;
            hex_val  <= '0;
            cnt      <= '0;
            mask     <= '0;
            ovf      <= 1'b0;
            hex_pend <= 1'b0;
            for (int i = 0; i < 6; i++) hex_q[i] <= 8'hFF;
        end else begin
            hex_pend <= accept && !bus.dec_mode;
            if (accept) begin
                mask <= bus.dp_mask;
                if (bus.dec_mode) begin
                    bin <= bus.value;
                    bcd <= '0;
                    cnt <= '0;
                    ovf <= bus.value > 24'd999999;
                end else begin
                    hex_val <= bus.value;
                end
            end else if (state == SHIFT) begin
                {bcd, bin} <= {bcd_adj, bin} << 1;
                cnt <= cnt + 1'b1;
            end
            if (hex_pend || commit)
                for (int i = 0; i < 6; i++) hex_q[i] <= nxt_seg[i];
        end
    end
    assign bus.hex0 = hex_q[0];
    assign bus.hex1 = hex_q[1];
    assign bus.hex2 = hex_q[2];
    assign bus.hex3 = hex_q[3];
    assign bus.hex4 = hex_q[4];
    assign bus.hex5 = hex_q[5];
endmodule

// File: doc/seg7_value_display.md
# seg7_value_display

Sequential six-digit seven-segment display controller for the DE10-Lite virtual-pin platform. Sits directly upstream of the pin IP's `seg7_0`..`seg7_5` inputs and replaces tied-off `8'b11111111` hex assignments in the top level. A user design presents a 24-bit value with a one-cycle load strobe. The block renders it as six hex digits, or converts it to decimal with an iterative double-dabble engine, then holds registered active-low segment patterns until the next accepted load.

## Interface
- `CONV_CYCLES`, 24: number of double-dabble shift iterations; must equal the value width.
- `max10_clk1_50`  in  1  50 MHz system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `value`  in  24  binary value to display; sampled on accepted load.
- `load`  in  1  one-cycle request; accepted only when `busy`=0.
- `dec_mode`  in  1  1 = decimal display, 0 = hex display; sampled with `load`.
- `dp_mask`  in  6  decimal-point enables, bit n → `hexn`; sampled with `load`.
- `busy`  out  1  conversion in progress; loads ignored while high.
- `hex0`..`hex5`  out  8 each  active-low segments. Bits 0–6 = a–g, bit 7 = DP. `hex0` is the least significant digit.

## Operation
- FSM states: IDLE, SHIFT, COMMIT.
- IDLE:
  - `load`=1 with `dec_mode`=0 → stay IDLE. Next edge drives the six hex nibbles directly to the outputs.
  - `load`=1 with `dec_mode`=1 → capture `value` into the shift register, clear the 24-bit BCD register and the iteration counter, go to SHIFT.
- SHIFT, once per cycle:
  - Add 3 to every BCD nibble ≥5.
  - Shift {BCD, binary} left by 1.
  - Increment the counter. After shift number `CONV_CYCLES`, go to COMMIT.
- COMMIT: decode BCD digits to segments, register the outputs, return to IDLE.
- Overflow: in decimal mode with captured value > 999999, every digit shows dash `8'hBF` (DP still per mask). Overflow is detected at capture. The FSM still runs the full sequence so latency is uniform.
- Segment codes:
  - Digits 0–9: C0 F9 A4 B0 99 92 82 F8 80 90.
  - A–F: 88 83 C6 A1 86 8E.
  - Dash: BF. Blank: FF.
- DP: bit 7 cleared when the corresponding `dp_mask` bit = 1. This applies to blanked digits too.
- `load` while `busy`=1: ignored. Nothing is queued, and the in-flight conversion and outputs are unaffected.
- Outputs change only on a hex-mode load edge or on the COMMIT edge. Otherwise they hold.

## Timing
- Reset (edge with `reset`=1):
  - State → IDLE.
  - `busy`=0.
  - `hex0`..`hex5`=`8'hFF`.
  - Internal registers cleared.
  - A conversion in progress is aborted, and its result is never committed.
- Hex mode: `load` accepted at edge k → outputs valid after edge k+1. `busy` stays 0.
- Decimal mode: `load` accepted at edge k.
  - `busy`=1 after edge k.
  - Shifts occur on edges k+1..k+24.
  - COMMIT occurs at edge k+25: outputs update and `busy` returns to 0 on the same edge.
  - A new `load` can be accepted at edge k+26.
- `load` and `reset` high on the same edge: reset wins.
- Back-to-back hex-mode loads: accepted every cycle. Each load updates the outputs one edge later.

## Configuration
- Macro `SEG7_LEADING_ZERO_BLANK_EN`:
  - Defined: in decimal mode, contiguous zero digits from `hex5` downward are blanked (`8'hFF` plus DP per mask). `hex0` is never blanked, so 0 shows as a single `C0`. Hex mode and overflow dashes are unaffected.
  - Undefined: all six digits are always displayed, including leading zeros.

## Test plan
- Decimal conversion: `value`=123456, `dec_mode`=1, `dp_mask`=0, load at edge k.
  - `busy`=1 for edges k..k+24.
  - After edge k+25: `hex5`..`hex0` = F9 A4 B0 99 92 82, and `busy`=0.
- Hex mode: `value`=24'hABCDEF, `dec_mode`=0, `dp_mask`=6'b000001.
  - One edge later: `hex5`..`hex0` = 88 83 C6 A1 86 0E.
  - `busy` never asserts.
- Leading zeros: `value`=42 in decimal mode.
  - Macro defined: `hex1`=99, `hex0`=A4, `hex5`..`hex2`=FF.
  - Macro undefined: `hex5`..`hex2`=C0.
- Overflow: `value`=1000000 in decimal mode → all six outputs = BF after 25 cycles.
- Busy and abort:
  - Load 999999. At edge k+10, load 5 in hex mode → ignored; final outputs are all `90`.
  - Repeat, asserting `reset` at edge k+12 → outputs `FF`, `busy`=0, and no later commit.
